instr_sequencer: RTL and testbench

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

---
 rtl/instr_sequencer.sv | 215 +++++++++++++++++++++
 tb/tb_instr_sequencer.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : instr_sequencer
// Brief    : Multi-cycle fetch/decode/execute sequencer that steers an ALU and
//            register file from a 16-bit program word stream.
// Revision : 1.0 - initial release
// ============================================================================
module instr_sequencer #(
   parameter int unsigned     PC_W     = 8,
   parameter logic [PC_W-1:0] START_PC = '0
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            run,
   output logic [PC_W-1:0] instr_addr,
   input  logic [15:0]     instr_data,
   input  logic [4:0]      flags,
   output logic [7:0]      aluop,
   output logic [4:0]      regen,
   output logic [4:0]      bufa,
   output logic [4:0]      bufb,
   output logic [15:0]     imm,
   output logic            immen,
   output logic            cin,
   output logic            busy,
   output logic            err
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_IMMF   = 3'd3,
      S_EXEC   = 3'd4,
      S_HALT   = 3'd5
   } state_t;

   localparam logic [3:0]      c_CLS_NOP  = 4'd0;
   localparam logic [3:0]      c_CLS_RR   = 4'd1;
   localparam logic [3:0]      c_CLS_RI   = 4'd2;
   localparam logic [3:0]      c_CLS_JMP  = 4'd3;
   localparam logic [3:0]      c_CLS_BRF  = 4'd4;
   localparam logic [3:0]      c_CLS_HALT = 4'd5;
   localparam logic [PC_W-1:0] c_PC_ONE   = PC_W'(1);
   localparam logic [PC_W-1:0] c_PC_TWO   = PC_W'(2);

   state_t          state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [PC_W-1:0] addr_q, addr_d;
   logic [15:0]     ir_q, ir_d;
   logic [15:0]     imm_q, imm_d;
   logic            err_q, err_d;
   logic [7:0]      aluop_q, aluop_d;
   logic [4:0]      regen_q, regen_d;
   logic [4:0]      bufa_q, bufa_d;
   logic [4:0]      bufb_q, bufb_d;
   logic            immen_q, immen_d;
   logic            cin_en_q, cin_en_d;
   logic            busy_q, busy_d;

   logic [3:0]      w_cls;
   logic [2:0]      w_cond;
   logic [7:0]      w_flags_ext;
   logic [PC_W-1:0] w_target;
   logic [PC_W-1:0] w_pc_inc;
   logic [15:0]     w_exec_src;

   assign w_cls       = instr_data[15:12];
   assign w_cond      = instr_data[2:0];
   assign w_flags_ext = {3'b000, flags};
   assign w_target    = PC_W'(instr_data[11:4]);
   assign w_pc_inc    = pc_q + c_PC_ONE;
   // RR executes straight from the word on the bus; RI from the latched word
   assign w_exec_src  = (state_q == S_IMMF) ? ir_q : instr_data;

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      addr_d   = addr_q;
      ir_d     = ir_q;
      imm_d    = imm_q;
      err_d    = err_q;
      aluop_d  = '0;
      regen_d  = '0;
      bufa_d   = '0;
      bufb_d   = '0;
      immen_d  = 1'b0;
      cin_en_d = 1'b0;

      case (state_q)
         S_IDLE, S_HALT: begin
            if (run) begin
               state_d = S_FETCH;
               pc_d    = START_PC;
            end
         end
         S_FETCH: begin
            state_d = S_DECODE;
         end
         S_DECODE: begin
            ir_d = instr_data;
            case (w_cls)
               c_CLS_NOP: begin
                  pc_d    = w_pc_inc;
                  state_d = S_FETCH;
               end
               c_CLS_RR: begin
                  state_d = S_EXEC;
               end
               c_CLS_RI: begin
                  state_d = S_IMMF;
               end
               c_CLS_JMP: begin
                  pc_d    = w_target;
                  state_d = S_FETCH;
               end
               c_CLS_BRF: begin
                  state_d = S_FETCH;
                  if (w_cond > 3'd4) begin
                     err_d = 1'b1;
                     pc_d  = w_pc_inc;
                  end else if (w_flags_ext[w_cond]) begin
                     pc_d = w_target;
                  end else begin
                     pc_d = w_pc_inc;
                  end
               end
               c_CLS_HALT: begin
                  state_d = S_HALT;
               end
               default: begin
                  err_d   = 1'b1;
                  pc_d    = w_pc_inc;
                  state_d = S_FETCH;
               end
            endcase
         end
         S_IMMF: begin
            imm_d   = instr_data;
            state_d = S_EXEC;
         end
         S_EXEC: begin
            pc_d    = (ir_q[15:12] == c_CLS_RI) ? pc_q + c_PC_TWO : w_pc_inc;
            state_d = S_FETCH;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (state_d == S_EXEC) begin
         regen_d  = {1'b1, w_exec_src[11:8]};
         bufa_d   = {1'b1, w_exec_src[11:8]};
         bufb_d   = (state_q == S_IMMF) ? 5'd0 : {1'b1, w_exec_src[7:4]};
         aluop_d  = {4'h0, w_exec_src[3:0]};
         immen_d  = (state_q == S_IMMF);
         cin_en_d = w_exec_src[3];
      end

      // The word after the opcode is requested during DECODE so an RI
      // immediate is on instr_data by IMMF; for other classes it is unused.
      if (state_d == S_FETCH) begin
         addr_d = pc_d;
      end else if (state_d == S_DECODE) begin
         addr_d = w_pc_inc;
      end

      busy_d = (state_d != S_IDLE) && (state_d != S_HALT);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         pc_q     <= START_PC;
         addr_q   <= START_PC;
         ir_q     <= '0;
         imm_q    <= '0;
         err_q    <= 1'b0;
         aluop_q  <= '0;
         regen_q  <= '0;
         bufa_q   <= '0;
         bufb_q   <= '0;
         immen_q  <= 1'b0;
         cin_en_q <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         addr_q   <= addr_d;
         ir_q     <= ir_d;
         imm_q    <= imm_d;
         err_q    <= err_d;
         aluop_q  <= aluop_d;
         regen_q  <= regen_d;
         bufa_q   <= bufa_d;
         bufb_q   <= bufb_d;
         immen_q  <= immen_d;
         cin_en_q <= cin_en_d;
         busy_q   <= busy_d;
      end
   end

   assign instr_addr = addr_q;
   assign aluop      = aluop_q;
   assign regen      = regen_q;
   assign bufa       = bufa_q;
   assign bufb       = bufb_q;
   assign imm        = imm_q;
   assign immen      = immen_q;
   assign cin        = cin_en_q & flags[0];
   assign busy       = busy_q;
   assign err        = err_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_sequencer
// Brief    : Instruction-level reference model and per-cycle compare for
//            instr_sequencer, with directed literal checks and random programs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_sequencer;

   localparam logic [7:0] c_START = 8'h00;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        run = 1'b0;
   logic [7:0]  instr_addr;
   logic [15:0] instr_data = '0;
   logic [4:0]  flags = '0;
   logic [7:0]  aluop;
   logic [4:0]  regen, bufa, bufb;
   logic [15:0] imm;
   logic        immen, cin, busy, err;

   instr_sequencer #(.PC_W(8), .START_PC(c_START)) dut (
      .clk        (clk),
      .reset      (reset),
      .run        (run),
      .instr_addr (instr_addr),
      .instr_data (instr_data),
      .flags      (flags),
      .aluop      (aluop),
      .regen      (regen),
      .bufa       (bufa),
      .bufb       (bufb),
      .imm        (imm),
      .immen      (immen),
      .cin        (cin),
      .busy       (busy),
      .err        (err)
   );

   always #5 clk = ~clk;

   logic [15:0] mem [256];
   always @(posedge clk) instr_data <= mem[instr_addr];

   int n_cmp  = 0;
   int n_fail = 0;

   // expected observable outputs for one clock cycle
   typedef struct packed {
      logic        busy;
      logic        chk_addr;
      logic [7:0]  addr;
      logic [4:0]  regen;
      logic [4:0]  bufa;
      logic [4:0]  bufb;
      logic [7:0]  aluop;
      logic        immen;
      logic        cin;
      logic [15:0] imm;
      logic        err;
   } exp_t;

   typedef enum int {M_IDLE, M_RUN, M_HALT} mode_t;

   exp_t        q[$];
   mode_t       m_mode = M_IDLE;
   logic [7:0]  m_pc   = c_START;
   logic        m_err  = 1'b0;
   logic [15:0] m_imm  = '0;
   logic [4:0]  m_flags = '0;
   logic        dir_en = 1'b1;
   logic [4:0]  dir_flags = '0;

   // Executes the instruction at m_pc architecturally and queues the cycles it occupies.
   task automatic expand();
      logic [15:0] w;
      logic [3:0]  cls, rd, rs, fn;
      logic [7:0]  pc1, tgt;
      exp_t        e;
      w   = mem[m_pc];
      cls = w[15:12]; rd = w[11:8]; rs = w[7:4]; fn = w[3:0];
      pc1 = m_pc + 8'd1;
      tgt = {rd, rs};
      e = '0; e.busy = 1'b1; e.imm = m_imm; e.err = m_err;
      e.chk_addr = 1'b1; e.addr = m_pc;
      q.push_back(e);
      e.chk_addr = 1'b0; e.addr = '0;
      case (cls)
         4'd1: begin
            q.push_back(e);
            e.regen = {1'b1, rd}; e.bufa = {1'b1, rd}; e.bufb = {1'b1, rs};
            e.aluop = {4'h0, fn}; e.cin = fn[3] & m_flags[0];
            q.push_back(e);
            m_pc = pc1;
         end
         4'd2: begin
            e.chk_addr = 1'b1; e.addr = pc1;
            q.push_back(e);
            e.chk_addr = 1'b0; e.addr = '0;
            q.push_back(e);
            m_imm = mem[pc1];
            e.imm = m_imm;
            e.regen = {1'b1, rd}; e.bufa = {1'b1, rd}; e.bufb = '0;
            e.aluop = {4'h0, fn}; e.immen = 1'b1; e.cin = fn[3] & m_flags[0];
            q.push_back(e);
            m_pc = m_pc + 8'd2;
         end
         4'd3: begin
            q.push_back(e);
            m_pc = tgt;
         end
         4'd4: begin
            q.push_back(e);
            if (fn[2:0] >= 3'd5) begin
               m_err = 1'b1;
               m_pc  = pc1;
            end else begin
               m_pc = m_flags[fn[2:0]] ? tgt : pc1;
            end
         end
         4'd5: begin
            q.push_back(e);
            m_mode = M_HALT;
         end
         4'd0: begin
            q.push_back(e);
            m_pc = pc1;
         end
         default: begin
            q.push_back(e);
            m_err = 1'b1;
            m_pc  = pc1;
         end
      endcase
   endtask

   always @(negedge clk) begin : p_cmp
      exp_t e, a;
      if (reset) begin
         e = '0; e.chk_addr = 1'b1; e.addr = c_START;
         q.delete();
         m_mode = M_IDLE; m_pc = c_START; m_err = 1'b0; m_imm = '0;
      end else begin
         if (q.size() == 0) begin
            if (m_mode == M_RUN) begin
               m_flags = dir_en ? dir_flags : 5'($urandom);
               flags   = m_flags;
               expand();
            end else begin
               e = '0; e.imm = m_imm; e.err = m_err;
               q.push_back(e);
               if (run) begin
                  m_mode = M_RUN;
                  m_pc   = c_START;
               end
            end
         end
         e = q.pop_front();
      end
      a.busy = busy; a.chk_addr = e.chk_addr; a.addr = e.chk_addr ? instr_addr : 8'h00;
      a.regen = regen; a.bufa = bufa; a.bufb = bufb; a.aluop = aluop;
      a.immen = immen; a.cin = cin; a.imm = imm; a.err = err;
      n_cmp = n_cmp + 1;
      if (a !== e) begin
         n_fail = n_fail + 1;
         $display("FAIL cycle t=%0t got=%h want=%h", $time, a, e);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      n_cmp = n_cmp + 1;
      if (act !== want) begin
         n_fail = n_fail + 1;
         $display("FAIL %s got=%h want=%h", name, act, want);
      end
   endtask

   task automatic hold_reset();
      @(posedge clk); #1 reset = 1'b1; run = 1'b0;
      for (int i = 0; i < 256; i++) mem[i] = 16'h5000;
   endtask

   task automatic release_reset();
      @(posedge clk); #1 reset = 1'b0;
   endtask

   task automatic pulse_run();
      @(posedge clk); #1 run = 1'b1;
      @(posedge clk); #1 run = 1'b0;
   endtask

   function automatic logic [15:0] rand_word();
      int r;
      logic [3:0] cls;
      r = $urandom_range(0, 99);
      if (r < 10)      cls = 4'd0;
      else if (r < 40) cls = 4'd1;
      else if (r < 60) cls = 4'd2;
      else if (r < 70) cls = 4'd3;
      else if (r < 85) cls = 4'd4;
      else if (r < 91) cls = 4'd5;
      else             cls = 4'($urandom_range(6, 15));
      return {cls, 12'($urandom)};
   endfunction

   initial begin
      // RR program, then reset while in EXEC
      hold_reset(); mem[0] = 16'h1123; dir_flags = 5'h1F; release_reset();
      pulse_run();
      @(negedge clk); chk("rr_fetch_addr", instr_addr, 8'h00);
      @(negedge clk); @(negedge clk);
      chk("rr_regen", regen, 5'h11);
      chk("rr_bufa", bufa, 5'h11);
      chk("rr_bufb", bufb, 5'h12);
      chk("rr_aluop", aluop, 8'h03);
      chk("rr_immen_cin", {immen, cin}, 2'b00);
      #1 reset = 1'b1;
      #1 chk("rst_exec_outs", {regen, bufa, bufb, aluop, immen, cin, busy, err}, 0);
      chk("rst_exec_addr_imm", {instr_addr, imm}, {c_START, 16'h0000});
      @(posedge clk); @(posedge clk); #1 reset = 1'b0;
      repeat (4) @(negedge clk);
      chk("idle_after_reset", {busy, regen}, 0);

      // RI with immediate
      hold_reset(); mem[0] = 16'h2405; mem[1] = 16'hBEEF; dir_flags = 5'h00; release_reset();
      pulse_run();
      repeat (4) @(negedge clk);
      chk("ri_imm", imm, 16'hBEEF);
      chk("ri_immen", immen, 1'b1);
      chk("ri_regen", regen, 5'h14);
      chk("ri_bufb", bufb, 5'h00);
      chk("ri_aluop", aluop, 8'h05);
      @(negedge clk); chk("ri_next_fetch", instr_addr, 8'h02);

      // BRF on carry, taken then not taken
      hold_reset(); mem[0] = 16'h4100; dir_flags = 5'h01; release_reset();
      pulse_run();
      repeat (3) @(negedge clk); chk("brf_taken_addr", instr_addr, 8'h10);
      hold_reset(); mem[0] = 16'h4100; dir_flags = 5'h00; release_reset();
      pulse_run();
      repeat (3) @(negedge clk); chk("brf_not_taken_addr", instr_addr, 8'h01);

      // illegal opcode then HALT, restart keeps err
      hold_reset(); mem[0] = 16'h7000; release_reset();
      pulse_run();
      repeat (5) @(negedge clk);
      chk("illegal_err", err, 1'b1);
      chk("halt_busy", busy, 1'b0);
      pulse_run();
      @(negedge clk);
      chk("restart_addr", instr_addr, 8'h00);
      chk("restart_err_sticky", err, 1'b1);

      // JMP to 0xFF holding an RI: immediate wraps to 0x00
      hold_reset(); mem[0] = 16'h3FF0; mem[8'hFF] = 16'h2123; release_reset();
      pulse_run();
      repeat (3) @(negedge clk); chk("jmp_target", instr_addr, 8'hFF);
      @(negedge clk); chk("wrap_imm_addr", instr_addr, 8'h00);
      repeat (2) @(negedge clk); chk("wrap_imm", imm, 16'h3FF0);
      @(negedge clk); chk("wrap_next_fetch", instr_addr, 8'h01);

      // random programs with random run pulses and occasional resets
      dir_en = 1'b0;
      for (int p = 0; p < 20; p++) begin
         hold_reset();
         for (int i = 0; i < 256; i++) mem[i] = rand_word();
         release_reset();
         for (int c = 0; c < 300; c++) begin
            @(posedge clk); #1;
            run = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 199) == 0) begin
               reset = 1'b1;
               @(posedge clk); #1 reset = 1'b0; run = 1'b0;
            end
         end
         run = 1'b0;
      end

      @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
